// File: rtl/train_pkg.sv
// Shared types and defaults for the train ETA predictor.
//   state_t    : predictor FSM states
//   TIME_W_DEF : default tick-counter / eta width
//   DIST_W_DEF : default distance width (cm)
//   ETA_SAT    : saturated eta value at the default width
package train_pkg;

  localparam int unsigned TIME_W_DEF = 19;
  localparam int unsigned DIST_W_DEF = 12;

  localparam logic [TIME_W_DEF-1:0] ETA_SAT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/eta_divider.sv
// Iterative restoring divider, one quotient bit per clock.
//   start    : loads dividend/divisor; PROD_W iterate cycles follow
//   dividend : numerator
//   divisor  : denominator, must be non-zero
//   done     : one-cycle pulse, quotient valid in that cycle
//   quotient : dividend / divisor (floor)
module eta_divider #(
  parameter int unsigned PROD_W = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] dividend,
  input  logic [PROD_W-1:0] divisor,
  output logic              done,
  output logic [PROD_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(PROD_W + 1);

  logic [PROD_W-1:0] rem_q;
  logic [PROD_W-1:0] div_q;
  logic [PROD_W-1:0] quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              running;
  logic [PROD_W:0]   rem_sh_c;
  logic [PROD_W:0]   diff_c;

  // Dividend bits shift out of quo_q's top as quotient bits shift into its bottom.
  always_comb begin
    rem_sh_c = {rem_q, quo_q[PROD_W-1]};
    diff_c   = rem_sh_c - {1'b0, div_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q   <= '0;
        quo_q   <= dividend;
        div_q   <= divisor;
        cnt_q   <= CNT_W'(PROD_W);
        running <= 1'b1;
      end else if (running) begin
        // Sign bit of the trial difference clear means the subtract fits.
        if (!diff_c[PROD_W]) begin
          rem_q <= diff_c[PROD_W-1:0];
          quo_q <= {quo_q[PROD_W-2:0], 1'b1};
        end else begin
          rem_q <= rem_sh_c[PROD_W-1:0];
          quo_q <= {quo_q[PROD_W-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/train_eta_predictor.sv
// Measures transit time between two track sensors and predicts arrival
// at a downstream point: eta = dist_pred*t_meas/dist_meas - margin.
//   tick                 : 1 ms strobe
//   s1_pulse / s2_pulse  : start / end of measurement
//   dist_meas, dist_pred : distances (cm), latched on s2_pulse
//   margin               : ms subtracted from the result, latched on s2_pulse
//   eta_ms, eta_valid    : prediction, held until eta_ready
//   busy                 : FSM not idle
//   err_timeout          : sticky, counter saturated before s2_pulse
//   err_zero_dist        : sticky, dist_meas was zero
//   err_clr              : clears both sticky flags
module train_eta_predictor
  import train_pkg::*;
#(
  parameter int unsigned TIME_W = TIME_W_DEF,
  parameter int unsigned DIST_W = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              s1_pulse,
  input  logic              s2_pulse,
  input  logic [DIST_W-1:0] dist_meas,
  input  logic [DIST_W-1:0] dist_pred,
  input  logic [TIME_W-1:0] margin,
  output logic [TIME_W-1:0] eta_ms,
  output logic              eta_valid,
  input  logic              eta_ready,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_zero_dist,
  input  logic              err_clr
);

  localparam int unsigned        PROD_W  = TIME_W + DIST_W;
  localparam logic [TIME_W-1:0]  CNT_MAX = '1;

  state_t             state;
  logic [TIME_W-1:0]  t_cnt;
  logic [TIME_W-1:0]  t_meas_q;
  logic [TIME_W-1:0]  margin_q;
  logic [DIST_W-1:0]  dist_meas_q;
  logic [DIST_W-1:0]  dist_pred_q;
  logic               div_go;
  logic               div_start_c;
  logic               div_done;
  logic [PROD_W-1:0]  dividend_c;
  logic [PROD_W-1:0]  quotient;
  logic [TIME_W-1:0]  result_c;
  logic               set_timeout_c;
  logic               set_zero_c;

  // div_go marks the first DIVIDE cycle, where the divider is loaded.
  assign set_zero_c    = (state == DIVIDE) && div_go && (dist_meas_q == '0);
  assign div_start_c   = div_go && (dist_meas_q != '0);
  assign dividend_c    = PROD_W'(dist_pred_q) * PROD_W'(t_meas_q);
  // s2 and s1 both outrank the tick that would saturate the counter.
  assign set_timeout_c = (state == TIMING) && !s2_pulse && !s1_pulse && tick &&
                         (t_cnt == CNT_MAX - TIME_W'(1));

  eta_divider #(.PROD_W(PROD_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend (dividend_c),
    .divisor  (PROD_W'(dist_meas_q)),
    .done     (div_done),
    .quotient (quotient)
  );

  // Saturate an oversized quotient, otherwise subtract margin clamped at zero.
  always_comb begin
    result_c = '0;
    if (quotient[PROD_W-1:TIME_W] != '0) begin
      result_c = CNT_MAX;
    end else if (quotient[TIME_W-1:0] >= margin_q) begin
      result_c = quotient[TIME_W-1:0] - margin_q;
    end
  end

  // Measurement FSM with tick counter, input latches and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      t_cnt       <= '0;
      t_meas_q    <= '0;
      margin_q    <= '0;
      dist_meas_q <= '0;
      dist_pred_q <= '0;
      div_go      <= 1'b0;
      eta_ms      <= '0;
      eta_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s1_pulse) begin
            t_cnt <= '0;
            state <= TIMING;
            busy  <= 1'b1;
          end
        end
        TIMING: begin
          if (s2_pulse) begin
            t_meas_q    <= t_cnt;
            dist_meas_q <= dist_meas;
            dist_pred_q <= dist_pred;
            margin_q    <= margin;
            div_go      <= 1'b1;
            state       <= DIVIDE;
          end else if (s1_pulse) begin
            t_cnt <= '0;
          end else if (tick) begin
            t_cnt <= t_cnt + TIME_W'(1);
            if (set_timeout_c) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DIVIDE: begin
          div_go <= 1'b0;
          if (set_zero_c) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (div_done) begin
            eta_ms    <= result_c;
            eta_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (eta_ready) begin
            eta_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; clear outranks a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout   <= 1'b0;
      err_zero_dist <= 1'b0;
    end else if (err_clr) begin
      err_timeout   <= 1'b0;
      err_zero_dist <= 1'b0;
    end else begin
      if (set_timeout_c) err_timeout   <= 1'b1;
      if (set_zero_c)    err_zero_dist <= 1'b1;
    end
  end

endmodule

// File: tb/tb_train_eta_predictor.sv
// Directed self-checking bench for train_eta_predictor.
module tb_train_eta_predictor;

  logic        clk;
  logic        rst_n;
  logic        tick, s1_pulse, s2_pulse;
  logic [11:0] dist_meas, dist_pred;
  logic [18:0] margin;
  logic [18:0] eta_ms;
  logic        eta_valid, eta_ready, busy, err_timeout, err_zero_dist, err_clr;

  // Narrow-counter instance for the timeout scenario
  logic        tick8, s1_8, s2_8;
  logic [7:0]  margin8;
  logic [7:0]  eta_ms8;
  logic        eta_valid8, busy8, err_timeout8, err_zero_dist8;

  int errors = 0;
  int checks = 0;

  train_eta_predictor dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .s1_pulse(s1_pulse), .s2_pulse(s2_pulse),
    .dist_meas(dist_meas), .dist_pred(dist_pred), .margin(margin),
    .eta_ms(eta_ms), .eta_valid(eta_valid), .eta_ready(eta_ready), .busy(busy),
    .err_timeout(err_timeout), .err_zero_dist(err_zero_dist), .err_clr(err_clr)
  );

  train_eta_predictor #(.TIME_W(8), .DIST_W(12)) dut8 (
    .clk(clk), .rst_n(rst_n), .tick(tick8), .s1_pulse(s1_8), .s2_pulse(s2_8),
    .dist_meas(dist_meas), .dist_pred(dist_pred), .margin(margin8),
    .eta_ms(eta_ms8), .eta_valid(eta_valid8), .eta_ready(eta_ready), .busy(busy8),
    .err_timeout(err_timeout8), .err_zero_dist(err_zero_dist8), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick = 0; s1_pulse = 0; s2_pulse = 0; eta_ready = 1; err_clr = 0;
    dist_meas = '0; dist_pred = '0; margin = '0;
    tick8 = 0; s1_8 = 0; s2_8 = 0; margin8 = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic pulse_s1();
    s1_pulse = 1; cyc(); s1_pulse = 0;
  endtask

  task automatic do_ticks(input int n);
    tick = 1; repeat (n) cyc(); tick = 0;
  endtask

  task automatic pulse_s2(input logic [11:0] dm, input logic [11:0] dp, input logic [18:0] mg);
    dist_meas = dm; dist_pred = dp; margin = mg;
    s2_pulse = 1; cyc(); s2_pulse = 0;
  endtask

  // Cycles from the s2 edge until eta_valid is seen; capped at 100.
  task automatic wait_valid(output int n);
    n = 0;
    while (!eta_valid && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({eta_ms, eta_valid, busy, err_timeout, err_zero_dist} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got eta=%0d v=%b busy=%b to=%b zd=%b, want all 0",
               eta_ms, eta_valid, busy, err_timeout, err_zero_dist);
    end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    pulse_s1();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    do_ticks(100);
    pulse_s2(12'd41, 12'd666, 19'd30);
    wait_valid(n);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL basic_latency: got %0d want 33", n); end
    checks++;
    if (eta_ms !== 19'd1594) begin errors++; $display("FAIL basic_eta: got %0d want 1594", eta_ms); end
    cyc();
    checks++;
    if (eta_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle_valid: got v=%b busy=%b want 0 0", eta_valid, busy);
    end
  endtask

  task automatic test_clamp();
    int n;
    pulse_s1();
    do_ticks(100);
    pulse_s2(12'd41, 12'd666, 19'd2000);
    wait_valid(n);
    checks++;
    if (n !== 33 || eta_ms !== 19'd0) begin
      errors++; $display("FAIL clamp_eta: got eta=%0d lat=%0d want 0 33", eta_ms, n);
    end
    cyc();
  endtask

  task automatic test_saturate();
    int n;
    pulse_s1();
    do_ticks(200);
    pulse_s2(12'd1, 12'd4095, 19'd0);
    wait_valid(n);
    checks++;
    if (eta_ms !== 19'h7FFFF) begin errors++; $display("FAIL saturate_eta: got %0d want 524287", eta_ms); end
    cyc();
  endtask

  task automatic test_zero_dist();
    bit seen;
    do_reset();
    pulse_s1();
    do_ticks(10);
    pulse_s2(12'd0, 12'd100, 19'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_n: got %b want 1", busy); end
    cyc();
    checks++;
    if (busy !== 1'b0 || err_zero_dist !== 1'b1) begin
      errors++; $display("FAIL zero_abort: got busy=%b zd=%b want 0 1", busy, err_zero_dist);
    end
    seen = 0;
    repeat (40) begin cyc(); if (eta_valid) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL zero_no_valid: got valid seen=%b want 0", seen); end
    err_clr = 1; cyc(); err_clr = 0;
    checks++;
    if (err_zero_dist !== 1'b0) begin errors++; $display("FAIL zero_clr: got %b want 0", err_zero_dist); end
    // Clear held across the setting edge wins.
    pulse_s1();
    do_ticks(5);
    pulse_s2(12'd0, 12'd100, 19'd0);
    err_clr = 1; cyc(); err_clr = 0;
    checks++;
    if (err_zero_dist !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_clr_priority: got zd=%b busy=%b want 0 0", err_zero_dist, busy);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    do_reset();
    s1_8 = 1; cyc(); s1_8 = 0;
    tick8 = 1; repeat (254) cyc();
    checks++;
    if (busy8 !== 1'b1 || err_timeout8 !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got busy=%b to=%b want 1 0", busy8, err_timeout8);
    end
    cyc(); tick8 = 0;
    checks++;
    if (busy8 !== 1'b0 || err_timeout8 !== 1'b1) begin
      errors++; $display("FAIL timeout_set: got busy=%b to=%b want 0 1", busy8, err_timeout8);
    end
    dist_meas = 12'd5; dist_pred = 12'd5;
    s2_8 = 1; cyc(); s2_8 = 0;
    seen = busy8;
    repeat (40) begin cyc(); if (eta_valid8 || busy8) seen = 1; end
    checks++;
    if (seen !== 1'b0 || err_timeout8 !== 1'b1) begin
      errors++; $display("FAIL timeout_s2_ignored: got active=%b to=%b want 0 1", seen, err_timeout8);
    end
  endtask

  task automatic test_stall();
    int n;
    bit bad;
    do_reset();
    eta_ready = 0;
    pulse_s1();
    do_ticks(50);
    pulse_s2(12'd7, 12'd100, 19'd5);
    wait_valid(n);
    checks++;
    if (eta_ms !== 19'd709) begin errors++; $display("FAIL stall_eta: got %0d want 709", eta_ms); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      s1_pulse = (i == 2); s2_pulse = (i == 5);
      cyc();
      if (eta_valid !== 1'b1 || eta_ms !== 19'd709) bad = 1;
    end
    s1_pulse = 0; s2_pulse = 0;
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL stall_hold: got unstable=%b want 0", bad); end
    eta_ready = 1; cyc();
    checks++;
    if (eta_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_release: got v=%b busy=%b want 0 0", eta_valid, busy);
    end
    pulse_s1();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_rearm: got busy=%b want 1", busy); end
  endtask

  task automatic test_restart();
    int n;
    bit seen;
    do_reset();
    pulse_s1(); do_ticks(50); pulse_s1(); do_ticks(20);
    pulse_s2(12'd10, 12'd10, 19'd0);
    wait_valid(n);
    checks++;
    if (n !== 33 || eta_ms !== 19'd20) begin
      errors++; $display("FAIL restart_eta: got eta=%0d lat=%0d want 20 33", eta_ms, n);
    end
    cyc();
    pulse_s1(); do_ticks(50); pulse_s1(); do_ticks(20);
    pulse_s2(12'd10, 12'd10, 19'd0);
    repeat (10) cyc();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({eta_ms, eta_valid, busy, err_timeout, err_zero_dist} !== 23'd0) begin
      errors++; $display("FAIL restart_async_reset: got eta=%0d v=%b busy=%b, want all 0",
                         eta_ms, eta_valid, busy);
    end
    cyc(); rst_n = 1;
    seen = 0;
    repeat (40) begin cyc(); if (eta_valid || busy) seen = 1; end
    checks++;
    if (seen !== 1'b0 || eta_ms !== 19'd0) begin
      errors++; $display("FAIL restart_no_result: got active=%b eta=%0d want 0 0", seen, eta_ms);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_saturate();
    test_zero_dist();
    test_timeout();
    test_stall();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/train_eta_predictor.md
# train_eta_predictor

Measures a train's transit time between two track sensors and predicts its arrival time at a downstream point. The prediction is computed once per measurement, after both sensors have fired. The design uses a single exact scaled division, eta = dist_pred·t_meas/dist_meas − margin, so no speed value is truncated to an integer along the way. The block sits between the sensor debounce logic and the signal/barrier controller, which consumes the prediction through a valid/ready handshake.

## Interface
- TIME_W, 19: width of the tick counter, margin and eta_ms.
- DIST_W, 12: width of the distance inputs, in cm.
- PROD_W, TIME_W+DIST_W (derived, not overridable): width of the product and of the quotient.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  1 ms time-base strobe, one cycle wide.
- s1_pulse  in  1  first sensor hit, one cycle wide; starts a measurement.
- s2_pulse  in  1  second sensor hit, one cycle wide; ends a measurement.
- dist_meas  in  DIST_W  distance from s1 to s2; sampled on s2_pulse.
- dist_pred  in  DIST_W  distance from s2 to the target; sampled on s2_pulse.
- margin  in  TIME_W  safety margin in ms, subtracted from the result; sampled on s2_pulse.
- eta_ms  out  TIME_W  predicted time to the target, in ms.
- eta_valid  out  1  eta_ms is valid.
- eta_ready  in  1  consumer accepts eta_ms.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  sticky; the counter saturated before s2_pulse arrived.
- err_zero_dist  out  1  sticky; dist_meas was 0 when sampled.
- err_clr  in  1  clears both sticky error flags.

## Operation
- States: IDLE, TIMING, DIVIDE, DONE.
- IDLE:
  - s1_pulse clears t_cnt and moves to TIMING.
  - s2_pulse is ignored.
- TIMING:
  - tick increments t_cnt.
  - When t_cnt reaches 2^TIME_W−1: set err_timeout and return to IDLE.
  - s1_pulse alone restarts the measurement: t_cnt ← 0, state stays TIMING.
  - s2_pulse latches t_meas = t_cnt (value before any same-cycle increment) and the three distance/margin inputs, then moves to DIVIDE.
  - s1_pulse and s2_pulse in the same cycle: s2 wins.
- DIVIDE:
  - Load dividend = dist_pred·t_meas (PROD_W bits) and divisor = dist_meas into eta_divider.
  - If dist_meas = 0: set err_zero_dist and return to IDLE without asserting eta_valid.
- DONE:
  - result = quotient − margin, clamped to 0 if negative.
  - If the quotient is ≥ 2^TIME_W, the result saturates to all ones.
  - eta_valid stays high and eta_ms stays stable until eta_ready is sampled high; then go to IDLE.
- All sensor pulses in DIVIDE and DONE are ignored and not queued.
- err_clr has priority over a same-cycle error set.
- Reset values: state IDLE, t_cnt 0, eta_ms 0, eta_valid 0, busy 0, both error flags 0.
- Reset mid-operation aborts immediately and asynchronously; no partial result is ever output.

## Timing
- s2_pulse is sampled at edge n.
- Divider load at edge n+1, then PROD_W iterate cycles (restoring, 1 quotient bit per cycle).
- eta_valid rises exactly PROD_W+2 cycles after the s2_pulse edge; 33 cycles at the default widths.
- Zero-distance abort: err_zero_dist is set and busy drops at edge n+1.
- Timeout: err_timeout is set and state is IDLE on the edge where the saturating tick is sampled.
- Handshake: a transfer occurs on a clock edge where eta_valid and eta_ready are both high. eta_ready may be held high permanently; eta_valid then lasts exactly one cycle.
- s1_pulse is accepted again the cycle after the return to IDLE.

## Structure
- Shared package train_pkg:
  - state enum.
  - TIME_W / DIST_W defaults.
  - ETA_SAT constant (all ones).
- Sub-module eta_divider (parameter PROD_W).
  - Interface: start, dividend, divisor, done, quotient.
  - Iterative restoring divider, no combinational divide.
- Top level contains: the FSM, the tick counter, the input latches, the subtract/clamp/saturate stage, and the error flags.

## Test plan
- s1, 100 ticks, s2 with dist_meas=41, dist_pred=666, margin=30 -> eta_ms=1594 (66600/41=1624, minus 30); eta_valid on cycle 33 after s2.
- Same run with margin=2000 -> eta_ms=0 (clamped).
- dist_meas=0 at s2 -> err_zero_dist=1, eta_valid never rises, busy low 1 cycle after s2; err_clr clears the flag.
- Override TIME_W=8: s1 then 255 ticks, no s2 -> err_timeout=1, state IDLE; a later s2 is ignored.
- eta_ready held low 10 cycles -> eta_ms stable, eta_valid high throughout; s1/s2 pulses in that window ignored; IDLE after the ready cycle.
- s1, 50 ticks, s1 again, 20 ticks, s2 (dist_meas=10, dist_pred=10, margin=0) -> eta_ms=20. Repeat with rst_n pulsed low mid-DIVIDE -> all outputs 0 and no eta_valid.
